uart_rx_core: RTL and testbench
===============================

// Module: uart_rx_core
// PURPOSE
//  UART receive engine; sits directly downstream of the UART clock generator and consumes its
//  16x-oversample baud_clock tick. Synchronises the serial rx line, detects and validates start
//  bits, deserialises 7/8 data bits LSB-first, checks optional parity and stop bit, and holds the
//  byte in a one-entry output register with ready/overflow/error flags for the host interface.
// PARAMETERS
//  SYNC_STAGES  2  flops in the rx input synchroniser (legal 2..3)
// PORTS
//  clk          in   1  system clock
//  reset        in   1  asynchronous, active-high reset
//  baud_clock   in   1  one-clk pulse at 16x bit rate (from clock generator)
//  rx           in   1  asynchronous serial input, idle high
//  bit8         in   1  1 = 8 data bits, 0 = 7 data bits
//  parity_en    in   1  1 = a parity bit follows the data bits
//  odd_n_even   in   1  1 = odd parity, 0 = even parity
//  read_rx_byte in   1  one-clk pulse: host has consumed rx_data
//  rx_data      out  8  received byte; bit7 = 0 in 7-bit mode
//  rx_ready     out  1  rx_data holds an unread byte
//  parity_err   out  1  sticky: parity mismatch on the held byte
//  framing_err  out  1  sticky: stop bit sampled low
//  overflow     out  1  sticky: byte completed while rx_ready was already 1
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, bit counter 0, synchroniser flops 1 (line idle).
//  - rx passes through SYNC_STAGES flops -> rx_s; all decisions use rx_s, only on baud_clock.
//  - tick counter cnt[3:0] counts baud_clock pulses within a bit, 0..15, wraps; at 15 the
//    FSM advances to the next bit. Sample point: cnt==7.
//  - FSM: IDLE -> START when rx_s==0 on a tick (that tick is cnt=0).
//    START: at cnt==7, rx_s==1 -> IDLE (false start, no flags); else continue; cnt==15 -> DATA.
//    DATA: sample at cnt==7 into shift reg (LSB first); after 8 (bit8=1) or 7 bits -> PARITY
//    if parity_en else STOP.
//    PARITY: sample at cnt==7; error if XOR(data bits, parity bit) != odd_n_even.
//    STOP: sample at cnt==7 then go straight to IDLE (no wait for cnt 15, allows back-to-back
//    frames); framing error if sample==0.
//  - Completion: one clk after the STOP sample, the byte is delivered:
//    rx_ready=0 -> rx_data loaded, rx_ready=1, parity_err/framing_err set from this frame.
//    rx_ready=1 and no read that clk -> byte discarded, rx_data unchanged, overflow=1.
//    read_rx_byte same clk as completion -> new byte loaded, rx_ready stays 1, overflow not set,
//    error flags replaced by the new frame's values.
//  - read_rx_byte with no completion: next clk rx_ready, parity_err, framing_err, overflow -> 0.
//    read_rx_byte while rx_ready=0: no effect.
//  - bit8/parity_en/odd_n_even are sampled at entry to START; changes mid-frame ignored.
//  - Reset mid-frame: frame abandoned, no flags, receiver returns to IDLE.
//  - Latency: rx falling edge to rx_ready = SYNC_STAGES clk + full frame up to STOP cnt==7 + 1 clk.
// CONFIGURATION
//  UART_RX_MAJORITY_EN defined: each sample (start validate, data, parity, stop) is the 2-of-3
//    majority of rx_s at cnt 6,7,8, decided at cnt==8; STOP exits to IDLE at cnt==8.
//  Not defined: single sample of rx_s at cnt==7 as above; no extra flops.
// TESTING
//  1 8N1, byte 0xA5, then read_rx_byte -> rx_data=0xA5, rx_ready=1, all errs 0; rx_ready=0 next clk.
//  2 7E1, send 0x41 with parity bit 1 -> rx_data=0x41, parity_err=1; with parity bit 0 -> err=0.
//  3 8O1, 0x00, stop bit driven 0 -> framing_err=1, rx_data=0x00, rx_ready=1.
//  4 8N1, 0x11 then 0x22 with no read -> rx_data=0x11, overflow=1; read clears all flags.
//  5 rx low pulse of 4 baud ticks from IDLE -> no rx_ready, FSM back in IDLE; next 0x3C received ok.
//  6 reset asserted during DATA bit 3 of 0x55, then clean 0x66 -> only 0x66 reported, no errs.

Source files
------------

// File: rtl/uart_rx_core_if.sv
// Host-side byte interface of the UART receiver: held byte, status flags and read strobe.
// master = receiver (drives byte and flags), slave = host (drives read_rx_byte).
interface uart_rx_core_if;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       parity_err;
  logic       framing_err;
  logic       overflow;
  logic       read_rx_byte;

  modport master (
    output rx_data, rx_ready, parity_err, framing_err, overflow,
    input  read_rx_byte
  );

  modport slave (
    input  rx_data, rx_ready, parity_err, framing_err, overflow,
    output read_rx_byte
  );
endinterface

// File: rtl/uart_rx_core.sv
// UART receiver on a 16x baud_clock tick; byte delivered 1 clk after the stop sample, no stall (unread byte -> overflow).
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling at cnt 6/7/8 instead of a single cnt 7 sample.
module uart_rx_core #(
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          baud_clock,
  input  logic          rx,
  input  logic          bit8,
  input  logic          parity_en,
  input  logic          odd_n_even,
  uart_rx_core_if.master host
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [3:0]             cnt, cnt_nxt;
  logic [2:0]             bitcnt, bitcnt_nxt;
  logic [7:0]             shreg, shreg_nxt;
  logic                   bit8_q, bit8_nxt;
  logic                   par_en_q, par_en_nxt;
  logic                   odd_q, odd_nxt;
  logic                   perr_q, perr_nxt;
  logic                   ferr_q, ferr_nxt;
  logic                   done_q, done_nxt;
  logic                   samp_strobe;
  logic                   samp_bit;

  logic [7:0]             rx_data_q;
  logic                   rx_ready_q;
  logic                   parity_err_q;
  logic                   framing_err_q;
  logic                   overflow_q;

  // synchroniser resets to 1 so a reset never looks like a start bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end
  assign rx_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] maj_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      maj_q <= 2'b11;
    end else if (baud_clock && state != IDLE) begin
      if (cnt == 4'd6) maj_q[0] <= rx_s;
      if (cnt == 4'd7) maj_q[1] <= rx_s;
    end
  end

  assign samp_strobe = baud_clock && (cnt == 4'd8);
  assign samp_bit    = (maj_q[0] & maj_q[1]) | (maj_q[0] & rx_s) | (maj_q[1] & rx_s);
`else
  assign samp_strobe = baud_clock && (cnt == 4'd7);
  assign samp_bit    = rx_s;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      bitcnt   <= 3'd0;
      shreg    <= 8'd0;
      bit8_q   <= 1'b0;
      par_en_q <= 1'b0;
      odd_q    <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bitcnt   <= bitcnt_nxt;
      shreg    <= shreg_nxt;
      bit8_q   <= bit8_nxt;
      par_en_q <= par_en_nxt;
      odd_q    <= odd_nxt;
      perr_q   <= perr_nxt;
      ferr_q   <= ferr_nxt;
      done_q   <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    bitcnt_nxt = bitcnt;
    shreg_nxt  = shreg;
    bit8_nxt   = bit8_q;
    par_en_nxt = par_en_q;
    odd_nxt    = odd_q;
    perr_nxt   = perr_q;
    ferr_nxt   = ferr_q;
    done_nxt   = 1'b0;
    if (baud_clock) begin
      cnt_nxt = cnt + 4'd1;
      case (state)
        IDLE: begin
          // the detecting tick is cnt 0 of the start bit
          cnt_nxt = 4'd0;
          if (!rx_s) begin
            state_nxt  = START;
            cnt_nxt    = 4'd1;
            bitcnt_nxt = 3'd0;
            shreg_nxt  = 8'd0;
            perr_nxt   = 1'b0;
            bit8_nxt   = bit8;
            par_en_nxt = parity_en;
            odd_nxt    = odd_n_even;
          end
        end
        START: begin
          if (samp_strobe && samp_bit) begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
          end else if (cnt == 4'd15) begin
            state_nxt = DATA;
          end
        end
        DATA: begin
          if (samp_strobe) shreg_nxt[bitcnt] = samp_bit;
          if (cnt == 4'd15) begin
            if (bitcnt == (bit8_q ? 3'd7 : 3'd6)) begin
              bitcnt_nxt = 3'd0;
              state_nxt  = par_en_q ? PARITY : STOP;
            end else begin
              bitcnt_nxt = bitcnt + 3'd1;
            end
          end
        end
        PARITY: begin
          if (samp_strobe) perr_nxt = ((^shreg) ^ samp_bit) != odd_q;
          if (cnt == 4'd15) state_nxt = STOP;
        end
        STOP: begin
          // leave at the sample point so a back-to-back start bit is not missed
          if (samp_strobe) begin
            ferr_nxt  = !samp_bit;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data_q     <= 8'd0;
      rx_ready_q    <= 1'b0;
      parity_err_q  <= 1'b0;
      framing_err_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else if (done_q) begin
      if (!rx_ready_q || host.read_rx_byte) begin
        rx_data_q     <= shreg;
        rx_ready_q    <= 1'b1;
        parity_err_q  <= perr_q;
        framing_err_q <= ferr_q;
        overflow_q    <= 1'b0;
      end else begin
        overflow_q    <= 1'b1;
      end
    end else if (host.read_rx_byte && rx_ready_q) begin
      rx_ready_q    <= 1'b0;
      parity_err_q  <= 1'b0;
      framing_err_q <= 1'b0;
      overflow_q    <= 1'b0;
    end
  end

  assign host.rx_data     = rx_data_q;
  assign host.rx_ready    = rx_ready_q;
  assign host.parity_err  = parity_err_q;
  assign host.framing_err = framing_err_q;
  assign host.overflow    = overflow_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Random and directed UART frames; expected bytes queued at send time, popped by a monitor that also performs the host read.
module tb_uart_rx_core;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       ovf;
  } exp_t;

  logic clk;
  logic reset;
  logic baud_clock;
  logic rx;
  logic bit8;
  logic parity_en;
  logic odd_n_even;

  uart_rx_core_if bus ();

  uart_rx_core #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .baud_clock (baud_clock),
    .rx         (rx),
    .bit8       (bit8),
    .parity_en  (parity_en),
    .odd_n_even (odd_n_even),
    .host       (bus)
  );

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   bdiv   = 0;
  logic hold   = 1'b0;

  logic [7:0] r_d;
  logic       r_b8, r_pen, r_odd, r_pbit, r_stop;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    baud_clock = 1'b0;
    forever begin
      @(negedge clk);
      bdiv       = (bdiv == 3) ? 0 : bdiv + 1;
      baud_clock = (bdiv == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
  endtask

  task automatic wait_ticks(input int n);
    int c = 0;
    while (c < n) begin
      @(posedge clk);
      if (baud_clock) c++;
    end
    #1;
  endtask

  task automatic drive(input logic b, input int n);
    rx = b;
    wait_ticks(n);
  endtask

  // reference: what the host should see for a frame, from the line-level description
  function automatic exp_t model(input logic [7:0] d, input logic b8, input logic pen,
                                 input logic odd, input logic pbit, input logic stopb);
    exp_t e;
    int   ones;
    e.data = b8 ? d : (d & 8'h7F);
    ones   = $countones(e.data) + (pbit ? 1 : 0);
    e.perr = pen && ((ones % 2) != (odd ? 1 : 0));
    e.ferr = !stopb;
    e.ovf  = 1'b0;
    return e;
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic b8, input logic pen, input logic odd,
                            input logic pbit, input logic stopb, input logic scramble, input int gap);
    bit8       = b8;
    parity_en  = pen;
    odd_n_even = odd;
    drive(1'b0, 16);
    if (scramble) begin
      bit8       = 1'($urandom_range(0, 1));
      parity_en  = 1'($urandom_range(0, 1));
      odd_n_even = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < (b8 ? 8 : 7); i++) drive(d[i], 16);
    if (pen) drive(pbit, 16);
    // a low stop bit is released early so the line reads idle before the next frame
    drive(stopb, 10);
    drive(1'b1, 6 + gap);
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic b8, input logic pen, input logic odd,
                              input logic pbit, input logic stopb, input int gap);
    exp_q.push_back(model(d, b8, pen, odd, pbit, stopb));
    send_frame(d, b8, pen, odd, pbit, stopb, 1'b0, gap);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: %0d entries pending, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  // monitor: compare each presented byte against the queue head, then read it
  initial begin
    exp_t e;
    bus.read_rx_byte = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && !hold && bus.rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_byte: actual rx_data 0x%0h, required no byte", bus.rx_data);
        end else begin
          e = exp_q.pop_front();
          chk("rx_data", {24'd0, bus.rx_data}, {24'd0, e.data});
          chk("parity_err", {31'd0, bus.parity_err}, {31'd0, e.perr});
          chk("framing_err", {31'd0, bus.framing_err}, {31'd0, e.ferr});
          chk("overflow", {31'd0, bus.overflow}, {31'd0, e.ovf});
        end
        bus.read_rx_byte = 1'b1;
        @(negedge clk);
        bus.read_rx_byte = 1'b0;
        chk("read_clears_flags",
            {28'd0, bus.rx_ready, bus.parity_err, bus.framing_err, bus.overflow}, 32'd0);
      end
    end
  end

  initial begin
    exp_t e;
    reset      = 1'b1;
    rx         = 1'b1;
    bit8       = 1'b1;
    parity_en  = 1'b0;
    odd_n_even = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_rx_data", {24'd0, bus.rx_data}, 32'd0);
    chk("reset_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
    chk("reset_parity_err", {31'd0, bus.parity_err}, 32'd0);
    chk("reset_framing_err", {31'd0, bus.framing_err}, 32'd0);
    chk("reset_overflow", {31'd0, bus.overflow}, 32'd0);
    wait_ticks(4);

    // 8N1 0xA5
    expect_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4);
    drain();
    // 7E1 0x41 with wrong then right parity bit
    expect_frame(8'h41, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4);
    expect_frame(8'h41, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4);
    drain();
    // 8O1 0x00 with stop bit low
    expect_frame(8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 20);
    drain();

    // overflow: two frames back-to-back with the host not reading
    hold = 1'b1;
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8);
    @(negedge clk);
    chk("ovf_rx_data", {24'd0, bus.rx_data}, 32'h11);
    chk("ovf_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
    chk("ovf_flag", {31'd0, bus.overflow}, 32'd1);
    e      = model(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    e.ovf  = 1'b1;
    exp_q.push_back(e);
    hold   = 1'b0;
    drain();

    // start-bit glitch of 4 ticks
    drive(1'b0, 4);
    drive(1'b1, 24);
    @(negedge clk);
    chk("glitch_no_ready", {31'd0, bus.rx_ready}, 32'd0);
    expect_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4);
    drain();

    // reset in the middle of data bit 3 of 0x55
    bit8 = 1'b1; parity_en = 1'b0;
    r_d = 8'h55;
    drive(1'b0, 16);
    for (int i = 0; i < 3; i++) drive(r_d[i], 16);
    drive(r_d[3], 8);
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    wait_ticks(24);
    @(negedge clk);
    chk("midframe_reset_ready", {31'd0, bus.rx_ready}, 32'd0);
    expect_frame(8'h66, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4);
    drain();

    // random frames, configuration scrambled mid-frame
    for (int k = 0; k < 24; k++) begin
      r_d    = 8'($urandom);
      r_b8   = 1'($urandom_range(0, 1));
      r_pen  = 1'($urandom_range(0, 1));
      r_odd  = 1'($urandom_range(0, 1));
      r_pbit = 1'($urandom_range(0, 1));
      r_stop = ($urandom_range(0, 5) != 0);
      exp_q.push_back(model(r_d, r_b8, r_pen, r_odd, r_pbit, r_stop));
      send_frame(r_d, r_b8, r_pen, r_odd, r_pbit, r_stop, 1'b1, r_stop ? $urandom_range(0, 3) : 20);
    end
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
